fwd_hazard_tracker: RTL and testbench
=====================================

Name: fwd_hazard_tracker

Overview:
- Producer-side control for the 3:1 32-bit operand-forwarding muxes in the EX stage of the 5-stage MIPS pipeline (D/E/M/W).
- Tracks the destination register and result-ready time of in-flight instructions.
- Each cycle it generates the 2-bit select codes that drive the rs/rt forwarding muxes, plus the load-use stall request.
- Sits beside the pipeline registers, fed from decode; outputs go to the E-stage muxes and to the D/F stall logic.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- d_rs  in  REG_AW  rs index of instruction in D.
- d_rt  in  REG_AW  rt index of instruction in D.
- d_rs_use  in  1  D instruction reads rs in E.
- d_rt_use  in  1  D instruction reads rt in E.
- d_dst  in  REG_AW  destination index of D instruction.
- d_we  in  1  D instruction writes the register file.
- d_tnew  in  2  result latency from E entry: 1 = ALU (ready at M), 2 = load (ready at W); 0 and 3 are illegal, treated as 2.
- stall  out  1  load-use stall; freezes F/D externally.
- e_sel_rs  out  2  E-stage rs mux select.
- e_sel_rt  out  2  E-stage rt mux select.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding matches the forwarding muxes:
  - 00 = register-file value from D/E register.
  - 01 = M-stage ALU result.
  - 10 = W-stage write-back data.
  - 11 is never driven.
- Internal records:
  - E record: rs, rt, rs_use, rt_use, dst, we, tnew.
  - M record and W record: dst, we, tnew.
  - A record with we=0 or dst=0 never matches anything; $0 is never forwarded and never stalls.
- Each rising edge:
  - W <= M; M <= E.
  - E <= D fields if stall=0.
  - E <= bubble if stall=1 (all use/we bits 0, indices 0).
- stall (combinational from D inputs and E record):
  - stall=1 iff E.we, E.dst!=0, E.tnew==2, and ((d_rs_use and d_rs==E.dst) or (d_rt_use and d_rt==E.dst)).
  - Only one stall cycle is ever needed per load-use pair: next cycle the load is in M and D sees no hazard.
- e_sel_rs (combinational from records; e_sel_rt is identical using rt):
  - If not E.rs_use: 00.
  - Else if M.we, M.dst!=0, M.dst==E.rs, M.tnew==1: 01.
  - Else if W.we, W.dst!=0, W.dst==E.rs: 10.
  - Else 00.
  - M has priority over W (youngest producer wins).
  - A load in M matching E.rs cannot occur (prevented by stall); if it does, fall through to W/00 and never select 01.
- Register file is write-through, so a W-stage write in the same cycle as a D read needs no tracking.
- stall_cnt increments by 1 on each edge where stall=1 and saturates at all-ones.
- Reset (asynchronous, reset_n low):
  - All records cleared to bubble; stall_cnt = 0.
  - Outputs therefore reset to stall=0, e_sel_rs=00, e_sel_rt=00.
  - Reset mid-stall discards the bubble and all in-flight records.
  - First edge after release loads E from D normally.
- rs==rt with both used: both selects are driven independently and identically.

Test Plan:
- Reset: hold reset_n=0 with random D inputs -> stall=0, both sels=00, stall_cnt=0; deassert, then issue a non-writing instruction -> sels stay 00.
- ALU back-to-back: addu $8 (we=1, tnew=1), then next cycle addu using rs=$8 -> when the consumer is in E, e_sel_rs=01, stall=0. One-gap consumer -> e_sel_rs=10. Two-gap consumer -> 00.
- Load-use: lw $9 (tnew=2) followed by an instruction with rt=$9, rt_use=1 -> stall=1 for exactly one cycle, stall_cnt=1, bubble enters E. Consumer then reaches E with e_sel_rt=10.
- Priority and $0:
  - Writers to $10 in both M and W, consumer rs=$10 -> e_sel_rs=01.
  - Writer dst=$0 (we=1) then consumer rs=$0 -> 00, no stall.
  - lw $0 then consumer of $0 -> no stall.
- Dual operand: rs=rt=$11 with a preceding ALU write to $11 -> e_sel_rs=e_sel_rt=01. With rs_use=0 -> e_sel_rs=00.
- Reset mid-stall: assert reset_n=0 during a stall=1 cycle -> stall drops to 0 immediately and stall_cnt=0. Force stall_cnt near all-ones (CNT_W=4) -> holds at 15.

Source files
------------

// File: rtl/fwd_hazard_tracker.sv
// fwd_hazard_tracker: EX-stage forwarding select and load-use stall control for a 5-stage pipeline.
// Ports: clk, reset_n (async active-low); d_* decode-stage instruction fields;
//        stall (freeze F/D), e_sel_rs/e_sel_rt (00 regfile, 01 M ALU, 10 W data),
//        stall_cnt (saturating stall-cycle count).
module fwd_hazard_tracker #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_rs_use,
  input  logic              d_rt_use,
  input  logic [REG_AW-1:0] d_dst,
  input  logic              d_we,
  input  logic [1:0]        d_tnew,
  output logic              stall,
  output logic [1:0]        e_sel_rs,
  output logic [1:0]        e_sel_rt,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [REG_AW-1:0] e_rs_q, e_rt_q, e_dst_q, m_dst_q, w_dst_q;
  logic [REG_AW-1:0] e_rs_d, e_rt_d, e_dst_d;
  logic              e_rs_use_q, e_rt_use_q, e_we_q, e_ld_q, m_we_q, m_ld_q, w_we_q;
  logic              e_rs_use_d, e_rt_use_d, e_we_d, e_ld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              e_live, m_live, w_live;
  // Records with we=0 or dst=$0 never produce a usable value.
  assign e_live = e_we_q && e_dst_q != '0;
  assign m_live = m_we_q && m_dst_q != '0;
  assign w_live = w_we_q && w_dst_q != '0;
  assign stall = e_live && e_ld_q &&
                 ((d_rs_use && d_rs == e_dst_q) || (d_rt_use && d_rt == e_dst_q));
  // A load sitting in M is never forwarded from M; its value is only valid at W.
  assign e_sel_rs = !e_rs_use_q ? 2'b00 :
                    (m_live && !m_ld_q && m_dst_q == e_rs_q) ? 2'b01 :
                    (w_live && w_dst_q == e_rs_q) ? 2'b10 : 2'b00;
  assign e_sel_rt = !e_rt_use_q ? 2'b00 :
                    (m_live && !m_ld_q && m_dst_q == e_rt_q) ? 2'b01 :
                    (w_live && w_dst_q == e_rt_q) ? 2'b10 : 2'b00;
  assign stall_cnt = cnt_q;
  always_comb begin
    e_rs_d     = stall ? '0 : d_rs;
    e_rt_d     = stall ? '0 : d_rt;
    e_dst_d    = stall ? '0 : d_dst;
    e_rs_use_d = !stall && d_rs_use;
    e_rt_use_d = !stall && d_rt_use;
    e_we_d     = !stall && d_we;
    // Only tnew==1 is an ALU result; every other code is treated as a load.
    e_ld_d     = !stall && d_tnew != 2'd1;
    cnt_d      = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_rs_q     <= '0;
      e_rt_q     <= '0;
      e_dst_q    <= '0;
      e_rs_use_q <= 1'b0;
      e_rt_use_q <= 1'b0;
      e_we_q     <= 1'b0;
      e_ld_q     <= 1'b0;
      m_dst_q    <= '0;
      m_we_q     <= 1'b0;
      m_ld_q     <= 1'b0;
      w_dst_q    <= '0;
      w_we_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      e_rs_q     <= e_rs_d;
      e_rt_q     <= e_rt_d;
      e_dst_q    <= e_dst_d;
      e_rs_use_q <= e_rs_use_d;
      e_rt_use_q <= e_rt_use_d;
      e_we_q     <= e_we_d;
      e_ld_q     <= e_ld_d;
      m_dst_q    <= e_dst_q;
      m_we_q     <= e_we_q;
      m_ld_q     <= e_ld_q;
      w_dst_q    <= m_dst_q;
      w_we_q     <= m_we_q;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// tb_fwd_hazard_tracker: directed checks of forwarding selects, load-use stall and stall counter.
module tb_fwd_hazard_tracker;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
  logic       d_rs_use = 1'b0, d_rt_use = 1'b0, d_we = 1'b0;
  logic [1:0] d_tnew = 2'd1;
  logic       stall;
  logic [1:0] e_sel_rs, e_sel_rt;
  logic [3:0] stall_cnt;
  int checks = 0;
  int errors = 0;
  fwd_hazard_tracker #(.REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .d_rs(d_rs), .d_rt(d_rt), .d_rs_use(d_rs_use),
    .d_rt_use(d_rt_use), .d_dst(d_dst), .d_we(d_we), .d_tnew(d_tnew),
    .stall(stall), .e_sel_rs(e_sel_rs), .e_sel_rt(e_sel_rt), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                       input logic rtu, input logic [4:0] dst, input logic we,
                       input logic [1:0] tnew);
    d_rs = rs; d_rt = rt; d_rs_use = rsu; d_rt_use = rtu;
    d_dst = dst; d_we = we; d_tnew = tnew;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 2'd1);
  endtask
  task automatic flush();
    nop();
    repeat (3) tick();
  endtask
  task automatic load_use();
    set_d(0, 0, 0, 0, 5'd13, 1, 2'd2);
    tick();
    set_d(5'd13, 0, 1, 0, 0, 0, 2'd1);
    tick();
    tick();
    flush();
  endtask
  initial begin
    set_d(5'($urandom), 5'($urandom), 1, 1, 5'($urandom), 1, 2'($urandom));
    tick();
    set_d(5'($urandom), 5'($urandom), 1, 1, 5'($urandom), 1, 2'd2);
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_sel_rs", e_sel_rs, 0);
    chk("rst_sel_rt", e_sel_rt, 0);
    chk("rst_cnt", stall_cnt, 0);
    set_d(5'd3, 5'd4, 1, 1, 5'd5, 0, 2'd1);
    reset_n = 1'b1;
    tick();
    tick();
    chk("nowrite_sel_rs", e_sel_rs, 0);
    chk("nowrite_sel_rt", e_sel_rt, 0);
    flush();
    // ALU back-to-back
    set_d(0, 0, 0, 0, 5'd8, 1, 2'd1);
    tick();
    set_d(5'd8, 0, 1, 0, 0, 0, 2'd1);
    chk("alu_b2b_nostall", stall, 0);
    tick();
    chk("alu_b2b_sel", e_sel_rs, 2'b01);
    flush();
    // one-gap consumer
    set_d(0, 0, 0, 0, 5'd8, 1, 2'd1);
    tick();
    nop();
    tick();
    set_d(5'd8, 0, 1, 0, 0, 0, 2'd1);
    tick();
    chk("alu_gap1_sel", e_sel_rs, 2'b10);
    flush();
    // two-gap consumer
    set_d(0, 0, 0, 0, 5'd8, 1, 2'd1);
    tick();
    nop();
    tick();
    tick();
    set_d(5'd8, 0, 1, 0, 0, 0, 2'd1);
    tick();
    chk("alu_gap2_sel", e_sel_rs, 2'b00);
    flush();
    // load-use
    set_d(0, 0, 0, 0, 5'd9, 1, 2'd2);
    tick();
    set_d(0, 5'd9, 0, 1, 0, 0, 2'd1);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_stall_once", stall, 0);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_bubble_sel_rt", e_sel_rt, 0);
    tick();
    chk("lu_fwd_w", e_sel_rt, 2'b10);
    flush();
    // M over W priority
    set_d(0, 0, 0, 0, 5'd10, 1, 2'd1);
    tick();
    tick();
    set_d(5'd10, 0, 1, 0, 0, 0, 2'd1);
    tick();
    chk("prio_m_over_w", e_sel_rs, 2'b01);
    flush();
    // $0 writer
    set_d(0, 0, 0, 0, 0, 1, 2'd1);
    tick();
    set_d(0, 0, 1, 0, 0, 0, 2'd1);
    chk("zero_nostall", stall, 0);
    tick();
    chk("zero_sel", e_sel_rs, 0);
    flush();
    // lw $0
    set_d(0, 0, 0, 0, 0, 1, 2'd2);
    tick();
    set_d(0, 0, 1, 1, 0, 0, 2'd1);
    chk("lw_zero_nostall", stall, 0);
    flush();
    // dual operand
    set_d(0, 0, 0, 0, 5'd11, 1, 2'd1);
    tick();
    set_d(5'd11, 5'd11, 1, 1, 0, 0, 2'd1);
    tick();
    chk("dual_rs", e_sel_rs, 2'b01);
    chk("dual_rt", e_sel_rt, 2'b01);
    flush();
    set_d(0, 0, 0, 0, 5'd11, 1, 2'd1);
    tick();
    set_d(5'd11, 5'd11, 0, 1, 0, 0, 2'd1);
    tick();
    chk("dual_rs_unused", e_sel_rs, 2'b00);
    chk("dual_rt_used", e_sel_rt, 2'b01);
    flush();
    // illegal tnew=0 behaves as a load
    set_d(0, 0, 0, 0, 5'd14, 1, 2'd0);
    tick();
    set_d(5'd14, 0, 1, 0, 0, 0, 2'd1);
    chk("tnew0_stall", stall, 1);
    tick();
    tick();
    chk("tnew0_fwd_w", e_sel_rs, 2'b10);
    chk("tnew0_cnt", stall_cnt, 2);
    flush();
    // reset mid-stall
    set_d(0, 0, 0, 0, 5'd12, 1, 2'd2);
    tick();
    set_d(5'd12, 0, 1, 0, 0, 0, 2'd1);
    chk("mid_stall_pre", stall, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_stall_drop", stall, 0);
    chk("mid_stall_cnt", stall_cnt, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_load_nostall", stall, 0);
    chk("post_rst_sel", e_sel_rs, 0);
    flush();
    // saturation
    repeat (14) load_use();
    chk("sat_14", stall_cnt, 14);
    load_use();
    chk("sat_15", stall_cnt, 15);
    repeat (2) load_use();
    chk("sat_hold", stall_cnt, 15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
